cordic_job_arbiter: RTL and testbench
=====================================

# cordic_job_arbiter

Round-robin job scheduler that shares one CORDIC engine among `NUM_REQ` requesters. It accepts one job at a time over per-requester valid/ready handshakes and launches it with a single-cycle `compute_start` pulse. It waits for `compute_done` under a watchdog, then returns the tagged result on a single response channel. It sits between client logic and the CORDIC host's `angle_in`/`cordic_mode`/`compute_start` inputs and its `result_x`/`result_y`/`compute_done` outputs.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥2 and a power of 2.
- `ANGLE_WIDTH`, 16: angle width; matches the engine.
- `TIMEOUT_CYCLES`, 32: watchdog limit in WAIT, counted from the first WAIT cycle; must be ≥12.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester job request.
- `req_ready` out NUM_REQ: one-hot grant/accept; a job is taken when valid&ready.
- `req_angle` in NUM_REQ*ANGLE_WIDTH: packed angles; requester i occupies `[i*ANGLE_WIDTH +: ANGLE_WIDTH]`.
- `req_mode` in NUM_REQ*2: packed modes; requester i occupies `[i*2 +: 2]`.
- `eng_start` out 1: to engine `compute_start`.
- `eng_angle` out ANGLE_WIDTH: to engine `angle_in`.
- `eng_mode` out 2: to engine `cordic_mode`.
- `eng_done` in 1: from engine `compute_done`.
- `eng_x` in 16: from engine `result_x`.
- `eng_y` in 16: from engine `result_y`.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out $clog2(NUM_REQ): index of the requester that owns the response.
- `rsp_x` out 16: returned x result.
- `rsp_y` out 16: returned y result.
- `rsp_timeout` out 1: watchdog expired; `rsp_x`/`rsp_y` are 0.
- `busy` out 1: high whenever state ≠ IDLE or `stale` = 1.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Internal registers: `rr_ptr`, `grant_id`, `wd_cnt`, `stale`.
- **IDLE**
  - If `stale` = 1: no grant is made. `eng_done` clears `stale`.
  - Otherwise, the grant goes to the first `req_valid` bit searching from `rr_ptr` upward, modulo `NUM_REQ`.
  - `req_ready[grant]` is asserted combinationally in the same cycle.
  - On handshake: latch angle, mode and `grant_id`, then go to ISSUE.
- **ISSUE**
  - `eng_start` = 1 for exactly this cycle.
  - Clear `wd_cnt`, then go to WAIT.
- **WAIT**
  - `wd_cnt` increments every cycle.
  - On `eng_done`: capture `eng_x`/`eng_y`, set `rsp_timeout` = 0, go to RESP.
  - Else if `wd_cnt` = `TIMEOUT_CYCLES-1`: set `rsp_x` = `rsp_y` = 0, `rsp_timeout` = 1, `stale` = 1, go to RESP.
  - If `eng_done` arrives in the timeout cycle, done wins.
- **RESP**
  - `rsp_valid` = 1, with `rsp_*` held stable until `rsp_ready`.
  - On `rsp_ready`: `rr_ptr` ← `grant_id`+1 (wraps to 0), go to IDLE.
  - `eng_done` seen in RESP while `stale` = 1 clears `stale`.
- `eng_angle`/`eng_mode` hold the latched job from ISSUE through RESP and keep their value in IDLE.
- `eng_done` outside WAIT never produces a response. Its only effect is clearing `stale`.
- Only one job is in flight at a time. `req_ready` is 0 in every state other than IDLE.

## Timing
- Reset values:
  - `req_ready` = 0, `eng_start` = 0, `eng_angle` = 0, `eng_mode` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_x` = 0, `rsp_y` = 0, `rsp_timeout` = 0.
  - `busy` = 0, `rr_ptr` = 0, `stale` = 0, state = IDLE.
- Accept cycle t, `eng_start` at t+1, WAIT from t+2.
- The nominal engine (8 stages) asserts done about 10 cycles after start. Response is then valid at done+1.
- Minimum spacing between accepts is 4 cycles (accept, ISSUE, WAIT with done, RESP with ready).
- Reset mid-job: all state returns to reset values immediately. No response is produced for the aborted job, and `stale` is cleared.
- Holding `rsp_ready` = 0 indefinitely holds the block in RESP. No requests are accepted meanwhile.
- Pointer wrap: a grant to `NUM_REQ-1` sets `rr_ptr` = 0.

## Test plan
- Single job, requester 2, angle 16'h1000, mode 0, done returned 10 cycles after start with x = 16'h1234, y = 16'h5678 → `req_ready` = 4'b0100 for one cycle; `eng_start` pulses once; `rsp_id` = 2, `rsp_x` = 16'h1234, `rsp_y` = 16'h5678, `rsp_timeout` = 0.
- All 4 `req_valid` held high, `rsp_ready` = 1 → grant order 0,1,2,3,0; each `eng_angle` matches the granted slot.
- Engine never returns done, `TIMEOUT_CYCLES` = 32 → `rsp_valid` 32 cycles after the first WAIT cycle, `rsp_timeout` = 1, x = y = 0. Afterwards no grant occurs until `eng_done` is pulsed, then the next grant happens.
- `rsp_ready` held 0 for 20 cycles with other requests pending → `rsp_*` stable and `req_ready` = 0 throughout. On release, the next grant is to `rsp_id`+1.
- `rst` asserted in WAIT → all outputs 0 asynchronously. A late `eng_done` after reset yields no response.
- `eng_done` in the same cycle `wd_cnt` hits its limit → normal response, `rsp_timeout` = 0, `stale` = 0.

Source files
------------

// File: rtl/cordic_job_arbiter.sv
// Round-robin scheduler that shares one CORDIC engine among NUM_REQ requesters.
// One job in flight at a time; a watchdog turns a silent engine into a timeout response.
//
// state | meaning
// IDLE  | searching for a requester from rr_ptr; blocked while stale
// ISSUE | single-cycle eng_start pulse, watchdog cleared
// WAIT  | waiting for eng_done under the watchdog
// RESP  | response held on rsp_* until rsp_ready
module cordic_job_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ANGLE_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
   input  logic [NUM_REQ*2-1:0]         req_mode,
   output logic                         eng_start,
   output logic [ANGLE_WIDTH-1:0]       eng_angle,
   output logic [1:0]                   eng_mode,
   input  logic                         eng_done,
   input  logic [15:0]                  eng_x,
   input  logic [15:0]                  eng_y,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [15:0]                  rsp_x,
   output logic [15:0]                  rsp_y,
   output logic                         rsp_timeout,
   output logic                         busy
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int WDW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   grant_id;
   logic [WDW-1:0]   wd_cnt;
   logic             stale;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   cand;
   logic             accept;
   logic             wd_expired;

   // First valid requester at or above rr_ptr; the index wraps naturally since NUM_REQ is 2^n.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = rr_ptr + IDW'(k);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign accept     = (state == IDLE) && !stale && gnt_found;
   assign wd_expired = (wd_cnt == WD_LAST);

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               req_ready[gnt_idx] = 1'b1;
               state_nxt          = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (eng_done || wd_expired)
               state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr      <= '0;
         grant_id    <= '0;
         wd_cnt      <= '0;
         stale       <= 1'b0;
         eng_angle   <= '0;
         eng_mode    <= '0;
         rsp_id      <= '0;
         rsp_x       <= '0;
         rsp_y       <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  grant_id  <= gnt_idx;
                  eng_angle <= req_angle[gnt_idx*ANGLE_WIDTH +: ANGLE_WIDTH];
                  eng_mode  <= req_mode[gnt_idx*2 +: 2];
               end
            end
            ISSUE: wd_cnt <= '0;
            WAIT: begin
               wd_cnt <= wd_cnt + 1'b1;
               // done wins over an expiring watchdog in the same cycle
               if (eng_done) begin
                  rsp_id      <= grant_id;
                  rsp_x       <= eng_x;
                  rsp_y       <= eng_y;
                  rsp_timeout <= 1'b0;
               end else if (wd_expired) begin
                  rsp_id      <= grant_id;
                  rsp_x       <= '0;
                  rsp_y       <= '0;
                  rsp_timeout <= 1'b1;
                  stale       <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready)
                  rr_ptr <= grant_id + IDW'(1);
            end
            default: ;
         endcase
         // a late done from an abandoned job releases the engine
         if (eng_done && state != WAIT)
            stale <= 1'b0;
      end
   end

   assign eng_start = (state == ISSUE);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE) || stale;

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Directed bench for cordic_job_arbiter: grant order, engine handshake,
// watchdog/stale handling, response backpressure and mid-job reset.
module tb_cordic_job_arbiter;

   localparam int NR = 4;
   localparam int AW = 16;
   localparam int TO = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*AW-1:0] req_angle;
   logic [NR*2-1:0]  req_mode;
   logic             eng_start;
   logic [AW-1:0]    eng_angle;
   logic [1:0]       eng_mode;
   logic             eng_done;
   logic [15:0]      eng_x;
   logic [15:0]      eng_y;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [15:0]      rsp_x;
   logic [15:0]      rsp_y;
   logic             rsp_timeout;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   cordic_job_arbiter #(.NUM_REQ(NR), .ANGLE_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_angle(req_angle), .req_mode(req_mode),
      .eng_start(eng_start), .eng_angle(eng_angle), .eng_mode(eng_mode),
      .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_timeout(rsp_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      settle();
   endtask

   function automatic logic [15:0] slot_angle(input int i);
      return 16'h1000 * 16'(i + 1) + 16'h0011 * 16'(i);
   endfunction

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_angle = '0;
      req_mode  = '0;
      eng_done  = 1'b0;
      eng_x     = '0;
      eng_y     = '0;
      rsp_ready = 1'b0;
      settle();

      // reset values
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_eng_start", 32'(eng_start), 0);
      chk("rst_eng_angle", 32'(eng_angle), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_busy", 32'(busy), 0);
      do_reset();

      // single job, requester 2, done 10 cycles after start
      req_angle[2*AW +: AW] = 16'h1000;
      req_mode[2*2 +: 2]    = 2'd0;
      req_valid             = 4'b0100;
      settle();
      chk("t1_req_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      settle();
      chk("t1_start", 32'(eng_start), 1);
      chk("t1_angle", 32'(eng_angle), 32'h1000);
      chk("t1_ready_off", 32'(req_ready), 0);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("t1_no_restart", 32'(eng_start), 0);
      end
      eng_done = 1'b1;
      eng_x    = 16'h1234;
      eng_y    = 16'h5678;
      tick();
      eng_done = 1'b0;
      settle();
      chk("t1_rsp_valid", 32'(rsp_valid), 1);
      chk("t1_rsp_id", 32'(rsp_id), 2);
      chk("t1_rsp_x", 32'(rsp_x), 32'h1234);
      chk("t1_rsp_y", 32'(rsp_y), 32'h5678);
      chk("t1_rsp_to", 32'(rsp_timeout), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      settle();
      chk("t1_idle_valid", 32'(rsp_valid), 0);
      chk("t1_idle_busy", 32'(busy), 0);

      // all requesters valid: grant order 0,1,2,3,0
      do_reset();
      for (int i = 0; i < NR; i++) begin
         req_angle[i*AW +: AW] = slot_angle(i);
         req_mode[i*2 +: 2]    = 2'(i);
      end
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      settle();
      for (int k = 0; k < 5; k++) begin
         chk("t2_grant", 32'(req_ready), 32'(1 << (k % NR)));
         tick();
         chk("t2_start", 32'(eng_start), 1);
         chk("t2_angle", 32'(eng_angle), 32'(slot_angle(k % NR)));
         chk("t2_mode", 32'(eng_mode), 32'(k % NR));
         tick();
         eng_done = 1'b1;
         eng_x    = 16'(k);
         tick();
         eng_done = 1'b0;
         settle();
         chk("t2_rsp_id", 32'(rsp_id), 32'(k % NR));
         chk("t2_rsp_x", 32'(rsp_x), 32'(k));
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b0;

      // watchdog timeout, then stale blocks grants until a late done
      do_reset();
      req_valid = 4'b0010;
      eng_x     = 16'hDEAD;
      eng_y     = 16'hBEEF;
      tick();
      req_valid = '0;
      tick();
      for (int i = 0; i < TO - 1; i++) tick();
      chk("t3_not_yet", 32'(rsp_valid), 0);
      tick();
      chk("t3_rsp_valid", 32'(rsp_valid), 1);
      chk("t3_rsp_to", 32'(rsp_timeout), 1);
      chk("t3_rsp_x", 32'(rsp_x), 0);
      chk("t3_rsp_y", 32'(rsp_y), 0);
      chk("t3_rsp_id", 32'(rsp_id), 1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      settle();
      for (int i = 0; i < 3; i++) begin
         chk("t3_stale_block", 32'(req_ready), 0);
         chk("t3_stale_busy", 32'(busy), 1);
         tick();
      end
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      settle();
      chk("t3_regrant", 32'(req_ready), 32'h4);
      chk("t3_busy_clear", 32'(busy), 0);
      tick();
      req_valid = '0;
      tick();
      eng_done = 1'b1;
      eng_x    = 16'h0042;
      tick();
      eng_done = 1'b0;
      settle();
      chk("t3_next_id", 32'(rsp_id), 2);
      chk("t3_next_to", 32'(rsp_timeout), 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // response backpressure with other requests pending
      do_reset();
      req_valid = 4'b1111;
      settle();
      tick();
      tick();
      eng_done = 1'b1;
      eng_x    = 16'hCAFE;
      eng_y    = 16'hF00D;
      tick();
      eng_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         eng_x = 16'(i);
         settle();
         chk("t4_hold_valid", 32'(rsp_valid), 1);
         chk("t4_hold_x", 32'(rsp_x), 32'hCAFE);
         chk("t4_hold_y", 32'(rsp_y), 32'hF00D);
         chk("t4_hold_id", 32'(rsp_id), 0);
         chk("t4_hold_ready", 32'(req_ready), 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      settle();
      chk("t4_next_grant", 32'(req_ready), 32'h2);
      req_valid = '0;

      // reset asserted in WAIT, late done ignored
      do_reset();
      req_angle[3*AW +: AW] = 16'h7777;
      req_mode[3*2 +: 2]    = 2'd3;
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();
      tick();
      tick();
      chk("t5_busy_wait", 32'(busy), 1);
      rst = 1'b1;
      settle();
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_angle", 32'(eng_angle), 0);
      chk("t5_rst_mode", 32'(eng_mode), 0);
      chk("t5_rst_start", 32'(eng_start), 0);
      chk("t5_rst_valid", 32'(rsp_valid), 0);
      tick();
      rst      = 1'b0;
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_no_rsp", 32'(rsp_valid), 0);
         chk("t5_idle_busy", 32'(busy), 0);
      end

      // done coincides with watchdog limit
      do_reset();
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      for (int i = 0; i < TO - 1; i++) tick();
      eng_done = 1'b1;
      eng_x    = 16'h0A0A;
      eng_y    = 16'h0B0B;
      tick();
      eng_done = 1'b0;
      settle();
      chk("t6_rsp_valid", 32'(rsp_valid), 1);
      chk("t6_rsp_to", 32'(rsp_timeout), 0);
      chk("t6_rsp_x", 32'(rsp_x), 32'h0A0A);
      chk("t6_rsp_y", 32'(rsp_y), 32'h0B0B);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      settle();
      chk("t6_no_stale", 32'(busy), 0);
      chk("t6_regrant", 32'(req_ready), 32'h1);
      req_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
